// File: rtl/bch_rx_checker.sv
// BCH(63,51) receive checker: deserialises a codeword MSB first, re-divides it by g(x), flags a nonzero remainder.
// Word valid the cycle after its 63rd bit; a full output buffer stalls only bit 62 of the next word. Optional err_cnt via BCH_RX_ERR_CNT_EN.
`timescale 1ns/1ps
module bch_rx_checker #(
  parameter int          N     = 63,
  parameter int          K     = 51,
  parameter logic [11:0] GPOLY = 12'h539
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_data,
  output logic         out_err
`ifdef BCH_RX_ERR_CNT_EN
  ,
  output logic [15:0]  err_cnt
`endif
);
  localparam int            CW        = $clog2(N);
  localparam logic [CW-1:0] LAST      = CW'(N - 1);
  localparam logic [CW-1:0] LAST_DATA = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [11:0]   rem;
  logic [11:0]   rem_nxt;
  logic [K-1:0]  shreg;
  logic          accept;
  logic          fb;
  logic          word_done;
  logic          pop;

  // Only the final bit of a word needs a free buffer slot; earlier bits land in shreg.
  assign in_ready  = !(cnt == LAST && out_valid && !out_ready);
  assign accept    = in_valid && in_ready;
  assign fb        = rem[11] ^ in_data;
  assign rem_nxt   = {rem[10:0], 1'b0} ^ (fb ? GPOLY : 12'h000);
  assign word_done = accept && !flush && (cnt == LAST);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      rem   <= '0;
      shreg <= '0;
      state <= IDLE;
    end else if (flush) begin
      cnt   <= '0;
      rem   <= '0;
      state <= IDLE;
    end else if (accept) begin
      if (state != PARITY)
        shreg <= {shreg[K-2:0], in_data};
      if (cnt == LAST) begin
        cnt   <= '0;
        rem   <= '0;
        state <= IDLE;
      end else begin
        cnt   <= cnt + CW'(1);
        rem   <= rem_nxt;
        state <= (cnt < LAST_DATA) ? DATA : PARITY;
      end
    end
  end

  // shreg already holds all K data bits once the parity phase starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else if (word_done) begin
      out_valid <= 1'b1;
      out_data  <= shreg;
      out_err   <= |rem_nxt;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

`ifdef BCH_RX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err_cnt <= '0;
    else if (word_done && (|rem_nxt) && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_bch_rx_checker.sv
// Directed bench for bch_rx_checker: table of codewords plus reset, backpressure and flush sequences.
`timescale 1ns/1ps
module tb_bch_rx_checker;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_data;
  logic        out_valid;
  logic        out_ready;
  logic [50:0] out_data;
  logic        out_err;
`ifdef BCH_RX_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  bch_rx_checker dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef BCH_RX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [50:0] data;
    logic [62:0] flip;
    logic [50:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];
  int   npass = 0;
  int   ntotal = 0;
  int   words_seen = 0;
  int   exp_errs = 0;

  localparam logic [50:0] D3 = 51'b011011011110110110001111011001011110011001101100011;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Long division of d(x)*x^12 by g(x) = x^12 + 0x539.
  function automatic logic [11:0] bch_parity(input logic [50:0] d);
    logic [62:0] r;
    r = {d, 12'b0};
    for (int i = 62; i >= 12; i--)
      if (r[i]) r[i -: 13] = r[i -: 13] ^ 13'h1539;
    return r[11:0];
  endfunction

  function automatic logic [62:0] codeword(input logic [50:0] d);
    return {d, bch_parity(d)};
  endfunction

  task automatic set_vec(input int idx, input string name, input logic [50:0] data,
                         input logic [62:0] flip, input logic [50:0] exp_data, input logic exp_err);
    vecs[idx].name     = name;
    vecs[idx].data     = data;
    vecs[idx].flip     = flip;
    vecs[idx].exp_data = exp_data;
    vecs[idx].exp_err  = exp_err;
  endtask

  // Sends cw[hi] down to cw[lo], one bit per accepted cycle; returns at the negedge after the last accept.
  task automatic send_range(input logic [62:0] cw, input int hi, input int lo);
    int waited;
    for (int i = hi; i >= lo; i--) begin
      waited = 0;
      in_valid = 1'b1;
      in_data  = cw[i];
      while (!in_ready && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
      if (out_valid) words_seen++;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    out_ready = 1'b1;
    send_range(codeword(v.data) ^ v.flip, 62, 0);
    if (v.exp_err) exp_errs++;
    check({v.name, "_valid"}, 64'(out_valid), 64'd1);
    check({v.name, "_data"},  64'(out_data),  64'(v.exp_data));
    check({v.name, "_err"},   64'(out_err),   64'(v.exp_err));
`ifdef BCH_RX_ERR_CNT_EN
    check({v.name, "_err_cnt"}, 64'(err_cnt), 64'(exp_errs));
`endif
    @(negedge clk);
    check({v.name, "_popped"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [50:0] a_dat;
    logic [50:0] b_dat;
    logic [50:0] c_dat;
    logic [62:0] cw_b;

    set_vec(0, "zero",     51'h0,               63'h0,                   51'h0,               1'b0);
    set_vec(1, "enc",      D3,                  63'h0,                   D3,                  1'b0);
    set_vec(2, "flip7",    D3,                  63'h80,                  D3,                  1'b1);
    set_vec(3, "flip62",   D3,                  63'h4000_0000_0000_0000,
            51'b111011011110110110001111011001011110011001101100011, 1'b1);
    set_vec(4, "ones",     51'h7_FFFF_FFFF_FFFF, 63'h0,                   51'h7_FFFF_FFFF_FFFF, 1'b0);
    set_vec(5, "flip2par", 51'h5_5555_5555_5555, 63'h21,                  51'h5_5555_5555_5555, 1'b1);
    set_vec(6, "burst4",   51'h2_AAAA_AAAA_AAAA, 63'hF0_0000,             51'h2_AAAA_AAAA_A5AA, 1'b1);

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-word with a word parked in the output buffer.
    out_ready = 1'b0;
    send_range(codeword(D3), 62, 0);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    send_range(codeword(51'h1_2345_6789_ABCD), 62, 43);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_data",  64'(out_data),  64'd0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    run_vec(vecs[1]);
    exp_errs = 0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Back-to-back words with the sink stalled.
    a_dat = 51'h1234_5678_9ABC;
    b_dat = 51'h7_0F0F_0F0F_0F0F;
    cw_b  = codeword(b_dat);
    out_ready = 1'b0;
    send_range(codeword(a_dat), 62, 0);
    check("bp_a_valid", 64'(out_valid), 64'd1);
    check("bp_a_data",  64'(out_data),  64'(a_dat));
    send_range(cw_b, 62, 1);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_data  = cw_b[0];
    repeat (3) @(negedge clk);
    check("bp_still_stalled", 64'(in_ready), 64'd0);
    check("bp_a_held",        64'(out_data), 64'(a_dat));
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_up", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_b_valid", 64'(out_valid), 64'd1);
    check("bp_b_data",  64'(out_data),  64'(b_dat));
    check("bp_b_err",   64'(out_err),   64'd0);
    @(negedge clk);
    check("bp_b_popped", 64'(out_valid), 64'd0);

    // Flush at cnt=30, then a clean word; the flushed bit must not count.
    c_dat = 51'h3_C3C3_C3C3_C3C3;
    out_ready = 1'b1;
    send_range(codeword(51'h6_DB6D_B6DB_6DB6), 62, 33);
    flush = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    words_seen = 0;
    send_range(codeword(c_dat), 62, 0);
    check("flush_valid",      64'(out_valid),  64'd1);
    check("flush_data",       64'(out_data),   64'(c_dat));
    check("flush_err",        64'(out_err),    64'd0);
    check("flush_word_count", 64'(words_seen), 64'd1);
    @(negedge clk);
    check("flush_popped", 64'(out_valid), 64'd0);
`ifdef BCH_RX_ERR_CNT_EN
    check("final_err_cnt", 64'(err_cnt), 64'(exp_errs));
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
